// File: rtl/eval_stack_pkg.sv
// eval_stack_pkg: shared definitions for the three-register evaluation stack.
//   op_e        : stack opcode (NOP / PUSH / POP / REDUCE), 2 bits
//   STACK_DEPTH : number of stack registers (Areg, Breg, Creg)
//   DEPTH_MAX   : STACK_DEPTH in the width of the depth counter
package eval_stack_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_PUSH   = 2'b01,
      OP_POP    = 2'b10,
      OP_REDUCE = 2'b11
   } op_e;

   localparam int         STACK_DEPTH = 3;
   localparam logic [1:0] DEPTH_MAX   = 2'(STACK_DEPTH);

endpackage

// File: rtl/eval_stack.sv
// eval_stack: Areg/Breg/Creg evaluation stack feeding the external adder.
// Areg drives adder B, Breg drives adder A; REDUCE writes the adder result
// back as the new top of stack. One op per cycle, 1-cycle latency, all
// outputs registered.
//   CLK, Reset_n : clock, asynchronous active-low reset
//   Op_Valid, Op : operation strobe and opcode
//   Push_Data    : value pushed on PUSH
//   Sum          : adder output, sampled on REDUCE
//   Clear_Err    : clears sticky Ovf/Unf (a same-cycle error still wins)
//   Top/Next/Third : Areg/Breg/Creg
//   Depth, Empty, Full : occupancy
//   Ovf, Unf     : sticky overflow / underflow flags
module eval_stack
   import eval_stack_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Op_Valid,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] Push_Data,
   input  logic [WIDTH-1:0] Sum,
   input  logic             Clear_Err,
   output logic [WIDTH-1:0] Top,
   output logic [WIDTH-1:0] Next,
   output logic [WIDTH-1:0] Third,
   output logic [1:0]       Depth,
   output logic             Empty,
   output logic             Full,
   output logic             Ovf,
   output logic             Unf
);

   logic [WIDTH-1:0] areg, breg, creg;
   logic [WIDTH-1:0] areg_n, breg_n, creg_n;
   logic [1:0]       depth, depth_n;
   logic             empty, full, ovf, unf;
   logic             ovf_set, unf_set;
   op_e              op;

   assign op = op_e'(Op);

   always_comb begin
      areg_n  = areg;
      breg_n  = breg;
      creg_n  = creg;
      depth_n = depth;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (Op_Valid) begin
         case (op)
            OP_PUSH: begin
               // When full the old Creg simply falls off the bottom.
               creg_n = breg;
               breg_n = areg;
               areg_n = Push_Data;
               if (depth == DEPTH_MAX) ovf_set = 1'b1;
               else                    depth_n = depth + 2'd1;
            end
            OP_POP: begin
               if (depth == 2'd0) begin
                  unf_set = 1'b1;
               end else begin
                  areg_n  = breg;
                  breg_n  = creg;
                  creg_n  = '0;
                  depth_n = depth - 2'd1;
               end
            end
            OP_REDUCE: begin
               if (depth < 2'd2) begin
                  unf_set = 1'b1;
               end else begin
                  areg_n  = Sum;
                  breg_n  = creg;
                  creg_n  = '0;
                  depth_n = depth - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         areg  <= '0;
         breg  <= '0;
         creg  <= '0;
         depth <= 2'd0;
         empty <= 1'b1;
         full  <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         areg  <= areg_n;
         breg  <= breg_n;
         creg  <= creg_n;
         depth <= depth_n;
         // Empty/Full registered alongside depth so no output is decoded
         empty <= (depth_n == 2'd0);
         full  <= (depth_n == DEPTH_MAX);
         ovf   <= (ovf & ~Clear_Err) | ovf_set;
         unf   <= (unf & ~Clear_Err) | unf_set;
      end
   end

   assign Top   = areg;
   assign Next  = breg;
   assign Third = creg;
   assign Depth = depth;
   assign Empty = empty;
   assign Full  = full;
   assign Ovf   = ovf;
   assign Unf   = unf;

endmodule

// File: tb/tb_eval_stack.sv
// tb_eval_stack: directed scoreboard bench for eval_stack. The bench models
// the external adder (Sum = Top + Next). The driver pushes the hand-computed
// post-edge state into a queue; the monitor pops and compares after each edge.
module tb_eval_stack;

   localparam logic [1:0] NOP = 2'b00, PSH = 2'b01, POP = 2'b10, RED = 2'b11;

   logic        CLK = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Op_Valid = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [15:0] Push_Data = '0;
   logic [15:0] Sum;
   logic        Clear_Err = 1'b0;
   logic [15:0] Top, Next, Third;
   logic [1:0]  Depth;
   logic        Empty, Full, Ovf, Unf;

   typedef struct packed {
      logic [15:0] top;
      logic [15:0] nxt;
      logic [15:0] third;
      logic [1:0]  depth;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        unf;
   } snap_t;

   snap_t expq[$];
   string nameq[$];
   int    errors = 0;
   int    checks = 0;

   eval_stack #(.WIDTH(16)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .Op_Valid(Op_Valid), .Op(Op),
      .Push_Data(Push_Data), .Sum(Sum), .Clear_Err(Clear_Err),
      .Top(Top), .Next(Next), .Third(Third), .Depth(Depth),
      .Empty(Empty), .Full(Full), .Ovf(Ovf), .Unf(Unf)
   );

   // external adder
   assign Sum = Top + Next;

   always #5 CLK = ~CLK;

   function automatic snap_t mk(logic [15:0] t, logic [15:0] n, logic [15:0] c,
                                logic [1:0] d, logic o, logic u);
      snap_t s;
      s.top = t; s.nxt = n; s.third = c; s.depth = d;
      s.empty = (d == 2'd0); s.full = (d == 2'd3);
      s.ovf = o; s.unf = u;
      return s;
   endfunction

   function automatic snap_t cur();
      snap_t s;
      s.top = Top; s.nxt = Next; s.third = Third; s.depth = Depth;
      s.empty = Empty; s.full = Full; s.ovf = Ovf; s.unf = Unf;
      return s;
   endfunction

   task automatic chk(input string nm, input snap_t e);
      snap_t a;
      a = cur();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got top=%h next=%h third=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, want top=%h next=%h third=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
                  nm, a.top, a.nxt, a.third, a.depth, a.empty, a.full, a.ovf, a.unf,
                  e.top, e.nxt, e.third, e.depth, e.empty, e.full, e.ovf, e.unf);
      end
   endtask

   // one op per cycle: drive at negedge, expectation checked after next posedge
   task automatic step(input string nm, input logic v, input logic [1:0] o,
                       input logic [15:0] d, input logic c, input snap_t e);
      @(negedge CLK);
      Op_Valid  = v;
      Op        = o;
      Push_Data = d;
      Clear_Err = c;
      expq.push_back(e);
      nameq.push_back(nm);
   endtask

   // monitor
   initial begin
      forever begin
         @(posedge CLK);
         if (expq.size() > 0) begin
            snap_t e;
            string nm;
            #1;
            e  = expq.pop_front();
            nm = nameq.pop_front();
            chk(nm, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, want done");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1 chk("reset_state", mk(16'h0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0));
      @(negedge CLK);
      Reset_n = 1'b1;

      step("idle_nop",      1, NOP, 16'h1111, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));
      step("invalid_push",  0, PSH, 16'h1234, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));

      // 5 + 8
      step("push5",         1, PSH, 16'h0005, 0, mk(16'h5, 16'h0, 16'h0, 2'd1, 0, 0));
      step("push8",         1, PSH, 16'h0008, 0, mk(16'h8, 16'h5, 16'h0, 2'd2, 0, 0));
      step("reduce_5_8",    1, RED, 16'h0000, 0, mk(16'hD, 16'h0, 16'h0, 2'd1, 0, 0));

      // asynchronous reset in the middle of a PUSH
      @(negedge CLK);
      Op_Valid = 1'b1; Op = PSH; Push_Data = 16'h0007; Clear_Err = 1'b0;
      #2 Reset_n = 1'b0;
      #1 chk("async_reset", mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));
      @(negedge CLK);
      Op_Valid = 1'b0;
      Reset_n  = 1'b1;

      // fill and overflow
      step("push1",         1, PSH, 16'h0001, 0, mk(16'h1, 16'h0, 16'h0, 2'd1, 0, 0));
      step("push2",         1, PSH, 16'h0002, 0, mk(16'h2, 16'h1, 16'h0, 2'd2, 0, 0));
      step("push3_full",    1, PSH, 16'h0003, 0, mk(16'h3, 16'h2, 16'h1, 2'd3, 0, 0));
      step("push4_ovf",     1, PSH, 16'h0004, 0, mk(16'h4, 16'h3, 16'h2, 2'd3, 1, 0));
      step("clear_ovf",     1, NOP, 16'h0000, 1, mk(16'h4, 16'h3, 16'h2, 2'd3, 0, 0));
      step("pop_3",         1, POP, 16'h0000, 0, mk(16'h3, 16'h2, 16'h0, 2'd2, 0, 0));
      step("pop_2",         1, POP, 16'h0000, 0, mk(16'h2, 16'h0, 16'h0, 2'd1, 0, 0));
      step("pop_1",         1, POP, 16'h0000, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));

      // underflow
      step("pop_empty",     1, POP, 16'h0000, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 1));
      step("clear_unf",     0, NOP, 16'h0000, 1, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));
      step("push9",         1, PSH, 16'h0009, 0, mk(16'h9, 16'h0, 16'h0, 2'd1, 0, 0));
      step("reduce_d1",     1, RED, 16'h0000, 0, mk(16'h9, 16'h0, 16'h0, 2'd1, 0, 1));
      step("clear_unf2",    1, NOP, 16'h0000, 1, mk(16'h9, 16'h0, 16'h0, 2'd1, 0, 0));
      step("pop_9",         1, POP, 16'h0000, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));

      // reduce from full depth: Creg moves up, bottom zeroed
      step("push_0a",       1, PSH, 16'h000A, 0, mk(16'h000A, 16'h0, 16'h0, 2'd1, 0, 0));
      step("push_14",       1, PSH, 16'h0014, 0, mk(16'h0014, 16'h000A, 16'h0, 2'd2, 0, 0));
      step("push_1e",       1, PSH, 16'h001E, 0, mk(16'h001E, 16'h0014, 16'h000A, 2'd3, 0, 0));
      step("reduce_full",   1, RED, 16'h0000, 0, mk(16'h0032, 16'h000A, 16'h0, 2'd2, 0, 0));
      step("pop_32",        1, POP, 16'h0000, 0, mk(16'h000A, 16'h0, 16'h0, 2'd1, 0, 0));
      step("pop_0a",        1, POP, 16'h0000, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));

      // wrap-around and clear/error collision
      step("push_ffff",     1, PSH, 16'hFFFF, 0, mk(16'hFFFF, 16'h0, 16'h0, 2'd1, 0, 0));
      step("push_0002",     1, PSH, 16'h0002, 0, mk(16'h0002, 16'hFFFF, 16'h0, 2'd2, 0, 0));
      step("reduce_wrap",   1, RED, 16'h0000, 0, mk(16'h0001, 16'h0, 16'h0, 2'd1, 0, 0));
      step("pop_wrap",      1, POP, 16'h0000, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 0));
      step("pop_empty_clr", 1, POP, 16'h0000, 1, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 1));
      step("hold_unf",      1, NOP, 16'h0000, 0, mk(16'h0, 16'h0, 16'h0, 2'd0, 0, 1));

      @(negedge CLK);
      Op_Valid  = 1'b0;
      Clear_Err = 1'b0;
      for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge CLK);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
